mem_wb_pipe: RTL and testbench

- Parametrised MEM/WB pipeline stage for the RISC-V core; replaces the fixed single-lane, always-advance MEM/WB register.
- Carries NCH independent write-back lanes (rd, wdata, wreg) from MEM to WB.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, a synchronous flush, and x0 write suppression.
- Sits between the MEM stage and the register file write port(s).

---
 rtl/mem_wb_pipe.sv | 127 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: NCH write-back lanes behind a 2-entry skid buffer.
// Registered in_ready, synchronous flush, optional x0 write suppression.
module mem_wb_pipe #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NCH           = 1,
  parameter bit ZERO_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*ADDR_W-1:0] mem_rd,
  input  logic [NCH*DATA_W-1:0] mem_wdata,
  input  logic [NCH-1:0]        mem_wreg,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [NCH*ADDR_W-1:0] wb_rd,
  output logic [NCH*DATA_W-1:0] wb_wdata,
  output logic [NCH-1:0]        wb_wreg,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   rdy_q;

  logic [NCH*ADDR_W-1:0] h_rd, s_rd;
  logic [NCH*DATA_W-1:0] h_wdata, s_wdata;
  logic [NCH-1:0]        h_wreg, s_wreg;
  logic [NCH-1:0]        cap_wreg;

  logic push, pop;
  logic ld_h_in, ld_h_s, ld_s;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    if (ZERO_SUPPRESS) begin : g_zs
      assign cap_wreg[i] = mem_wreg[i] &
                           (|mem_rd[i*ADDR_W +: ADDR_W]);
    end else begin : g_nzs
      assign cap_wreg[i] = mem_wreg[i];
    end
  end

  assign wb_valid  = (state_q != EMPTY);
  assign in_ready  = rdy_q;
  assign push      = in_valid & rdy_q;
  assign pop       = wb_valid & wb_ready;
  assign occupancy = state_q;
  assign wb_rd     = h_rd;
  assign wb_wdata  = h_wdata;
  assign wb_wreg   = h_wreg & {NCH{wb_valid}};

  always_comb begin
    state_d = state_q;
    ld_h_in = 1'b0;
    ld_h_s  = 1'b0;
    ld_s    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            ld_h_in = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            ld_s    = 1'b1;
          end else if (push && pop) begin
            ld_h_in = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            ld_h_s  = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes from the next state so it never sees wb_ready combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      h_rd    <= '0;
      h_wdata <= '0;
      h_wreg  <= '0;
      s_rd    <= '0;
      s_wdata <= '0;
      s_wreg  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != TWO);
      if (ld_h_in) begin
        h_rd    <= mem_rd;
        h_wdata <= mem_wdata;
        h_wreg  <= cap_wreg;
      end else if (ld_h_s) begin
        h_rd    <= s_rd;
        h_wdata <= s_wdata;
        h_wreg  <= s_wreg;
      end
      if (ld_s) begin
        s_rd    <= mem_rd;
        s_wdata <= mem_wdata;
        s_wreg  <= cap_wreg;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe with two lanes.
// Directed vectors; a negedge monitor checks every bundle WB consumes.
module tb_mem_wb_pipe;
  localparam int NCH = 2;
  localparam int AW  = 5;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic wb_ready = 1'b0;
  logic [NCH*AW-1:0] mem_rd = '0;
  logic [NCH*DW-1:0] mem_wdata = '0;
  logic [NCH-1:0]    mem_wreg = '0;
  logic              in_ready;
  logic              wb_valid;
  logic [NCH*AW-1:0] wb_rd;
  logic [NCH*DW-1:0] wb_wdata;
  logic [NCH-1:0]    wb_wreg;
  logic [1:0]        occupancy;

  mem_wb_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .NCH(NCH), .ZERO_SUPPRESS(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_rd(mem_rd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH*AW-1:0] rd;
    logic [NCH*DW-1:0] wd;
    logic [NCH-1:0]    wr;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // inputs change at posedge+1, so the negedge view matches the next edge
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      if (wb_valid && wb_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got rd %h expected none", wb_rd);
        end else begin
          e = q.pop_front();
          chk("sb_rd", 64'(wb_rd), 64'(e.rd));
          chk("sb_wdata", wb_wdata, e.wd);
          chk("sb_wreg", 64'(wb_wreg), 64'(e.wr));
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(cur);
    end
  end

  task automatic step(input logic v, input logic [NCH*AW-1:0] r,
                      input logic [NCH*DW-1:0] d, input logic [NCH-1:0] w,
                      input logic [NCH-1:0] ew, input logic rdy,
                      input logic fl);
    in_valid  = v;
    mem_rd    = r;
    mem_wdata = d;
    mem_wreg  = w;
    cur       = '{rd: r, wd: d, wr: ew};
    wb_ready  = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    in_valid  = 1'b1;
    mem_rd    = {5'd6, 5'd5};
    mem_wdata = {32'h1234_5678, 32'hDEAD_BEEF};
    mem_wreg  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_wdata", wb_wdata, 64'd0);
    chk("rst_wb_wreg", 64'(wb_wreg), 64'd0);

    rst = 1'b1;
    step(1'b1, {5'd6, 5'd5}, {32'h1234_5678, 32'hDEAD_BEEF},
         2'b11, 2'b11, 1'b0, 1'b0);
    chk("first_valid", 64'(wb_valid), 64'd1);
    chk("first_rd", 64'(wb_rd), 64'h0C5);
    chk("first_wdata", wb_wdata, 64'h1234_5678_DEAD_BEEF);
    chk("first_occ", 64'(occupancy), 64'd1);
    idle(1'b1);
    chk("first_drain_occ", 64'(occupancy), 64'd0);

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, {5'(i + 16), 5'(i)}, {32'h200 + i, 32'h100 + i},
           2'b11, 2'b11, 1'b1, 1'b0);
      chk("stream_occ", 64'(occupancy), 64'd1);
      chk("stream_rd", 64'(wb_rd[4:0]), 64'(i));
    end
    idle(1'b1);
    chk("stream_drain_occ", 64'(occupancy), 64'd0);

    step(1'b1, {5'd11, 5'd10}, {32'hA1, 32'hA0}, 2'b11, 2'b11,
         1'b0, 1'b0);
    chk("bp_a_occ", 64'(occupancy), 64'd1);
    chk("bp_a_rdy", 64'(in_ready), 64'd1);
    step(1'b1, {5'd13, 5'd12}, {32'hB1, 32'hB0}, 2'b01, 2'b01,
         1'b0, 1'b0);
    chk("bp_b_occ", 64'(occupancy), 64'd2);
    chk("bp_b_rdy", 64'(in_ready), 64'd0);
    repeat (2) begin
      step(1'b1, {5'd15, 5'd14}, {32'hC1, 32'hC0}, 2'b10, 2'b10,
           1'b0, 1'b0);
      chk("bp_hold_occ", 64'(occupancy), 64'd2);
      chk("bp_hold_head", 64'(wb_rd), 64'h16A);
    end
    step(1'b1, {5'd15, 5'd14}, {32'hC1, 32'hC0}, 2'b10, 2'b10,
         1'b1, 1'b0);
    chk("bp_pop_occ", 64'(occupancy), 64'd1);
    chk("bp_pop_rdy", 64'(in_ready), 64'd1);
    step(1'b1, {5'd15, 5'd14}, {32'hC1, 32'hC0}, 2'b10, 2'b10,
         1'b1, 1'b0);
    chk("bp_c_occ", 64'(occupancy), 64'd1);
    idle(1'b1);
    chk("bp_drain_occ", 64'(occupancy), 64'd0);

    step(1'b1, {5'd2, 5'd1}, {32'hD1, 32'hD0}, 2'b11, 2'b11,
         1'b0, 1'b0);
    step(1'b1, {5'd4, 5'd3}, {32'hE1, 32'hE0}, 2'b11, 2'b11,
         1'b0, 1'b0);
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    step(1'b1, {5'd9, 5'd8}, {32'hF1, 32'hF0}, 2'b11, 2'b11,
         1'b0, 1'b1);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_valid", 64'(wb_valid), 64'd0);
    chk("fl_wreg", 64'(wb_wreg), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);
    chk("fl_no_ghost", 64'(wb_valid), 64'd0);

    step(1'b1, {5'd7, 5'd0}, {32'h77, 32'h55}, 2'b11, 2'b10,
         1'b0, 1'b0);
    chk("x0_wreg", 64'(wb_wreg), 64'h2);
    chk("x0_wdata0", 64'(wb_wdata[31:0]), 64'h55);
    chk("x0_rd0", 64'(wb_rd[4:0]), 64'd0);
    step(1'b1, {5'd0, 5'd3}, {32'h66, 32'h33}, 2'b11, 2'b01,
         1'b1, 1'b0);
    step(1'b1, {5'd9, 5'd8}, {32'h99, 32'h88}, 2'b00, 2'b00,
         1'b1, 1'b0);
    idle(1'b1);
    chk("x0_drain_occ", 64'(occupancy), 64'd0);

    step(1'b1, {5'd17, 5'd16}, {32'h611, 32'h610}, 2'b11, 2'b11,
         1'b0, 1'b0);
    step(1'b1, {5'd19, 5'd18}, {32'h711, 32'h710}, 2'b11, 2'b11,
         1'b0, 1'b0);
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(wb_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_rdy", 64'(in_ready), 64'd1);
    chk("ar_wreg", 64'(wb_wreg), 64'd0);
    chk("ar_rd", 64'(wb_rd), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, {5'd21, 5'd20}, {32'h811, 32'h810}, 2'b11, 2'b11,
         1'b1, 1'b0);
    chk("ar_post_occ", 64'(occupancy), 64'd1);
    chk("ar_post_rd", 64'(wb_rd), 64'h2B4);
    idle(1'b1);
    idle(1'b1);
    chk("ar_post_drain", 64'(occupancy), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
